// File: rtl/segled_serial_rx_if.sv
// segled_serial_rx_if: serial seven-segment link (shift clock, clear, data, latch strobe).
interface segled_serial_rx_if;
    logic SEGLED_CLK;
    logic SEGLED_CLR;
    logic SEGLED_DO;
    logic SEGLED_PEN;
    modport master (output SEGLED_CLK, SEGLED_CLR, SEGLED_DO, SEGLED_PEN);
    modport slave  (input  SEGLED_CLK, SEGLED_CLR, SEGLED_DO, SEGLED_PEN);
endinterface

// File: rtl/segled_serial_rx.sv
// segled_serial_rx: oversampling receiver for the serial seven-segment link, latching frames on PEN.
// Define SEGLED_RX_DECODE_EN to build the per-digit hex glyph decoder driving hex/hex_ok.
module segled_serial_rx #(
    parameter int NBITS = 64,
    parameter int CNTW  = 7
) (
    input  logic              clk,
    input  logic              RSTN,
    segled_serial_rx_if.slave link,
    output logic [NBITS-1:0]  frame,
    output logic              frame_valid,
    output logic              frame_err,
    output logic              overflow,
    output logic [CNTW-1:0]   bit_count,
    output logic [31:0]       hex,
    output logic [7:0]        hex_ok
);
    typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_t;
    localparam logic [CNTW-1:0] NB = CNTW'(NBITS);
    state_t state, state_sh, state_d;
    logic [3:0] s1, s2;
    logic [1:0] s3;
    logic clk_rise, pen_rise, clr_n, do_s, ovf_set;
    logic [NBITS-1:0] sr, sr_d;
    logic [CNTW-1:0] cnt_inc, cnt_sh, cnt_d;
    // Sync order {CLK, PEN, CLR, DO}; DO shares the CLK pipeline depth to stay aligned.
    always_ff @(posedge clk or negedge RSTN)
        if (!RSTN) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= {link.SEGLED_CLK, link.SEGLED_PEN, link.SEGLED_CLR, link.SEGLED_DO};
            s2 <= s1;
            s3 <= s2[3:2];
        end
    assign clk_rise = s2[3] & ~s3[1];
    assign pen_rise = s2[2] & ~s3[0];
    assign clr_n    = s2[1];
    assign do_s     = s2[0];
    assign cnt_inc  = bit_count + CNTW'(1);
    always_ff @(posedge clk or negedge RSTN)
        if (!RSTN) state <= IDLE;
        else state <= state_d;
    // Shift resolves before commit so a coincident PEN includes the new bit.
    always_comb begin
        sr_d     = sr;
        cnt_sh   = bit_count;
        state_sh = state;
        ovf_set  = 1'b0;
        if (!clr_n) begin
            sr_d     = '0;
            cnt_sh   = '0;
            state_sh = IDLE;
        end else if (clk_rise) begin
            sr_d     = {sr[NBITS-2:0], do_s};
            ovf_set  = state == FULL;
            cnt_sh   = state == FULL ? bit_count : cnt_inc;
            state_sh = (state == FULL || cnt_inc == NB) ? FULL : SHIFT;
        end
        state_d = pen_rise ? IDLE : state_sh;
        cnt_d   = pen_rise ? '0 : cnt_sh;
    end
    always_ff @(posedge clk or negedge RSTN)
        if (!RSTN) begin
            sr          <= '0;
            bit_count   <= '0;
            frame       <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            sr          <= sr_d;
            bit_count   <= cnt_d;
            frame_valid <= pen_rise;
            overflow    <= overflow | ovf_set;
            if (pen_rise) begin
                frame     <= sr_d;
                frame_err <= frame_err | (cnt_sh != NB);
            end
        end
`ifdef SEGLED_RX_DECODE_EN
    // Active-low glyphs for 0..F, decimal point excluded.
    localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [31:0] hex_d;
    logic [7:0]  ok_d;
    always_comb begin
        hex_d = '0;
        ok_d  = '0;
        for (int i = 0; i < 8; i++)
            for (int g = 0; g < 16; g++)
                if (sr_d[8*i +: 7] == GLYPH[g]) begin
                    hex_d[4*i +: 4] = 4'(g);
                    ok_d[i]         = 1'b1;
                end
    end
    always_ff @(posedge clk or negedge RSTN)
        if (!RSTN) begin
            hex    <= '0;
            hex_ok <= '0;
        end else if (pen_rise) begin
            hex    <= hex_d;
            hex_ok <= ok_d;
        end
`else
    assign hex    = '0;
    assign hex_ok = '0;
`endif
endmodule

// File: tb/tb_segled_serial_rx.sv
// tb_segled_serial_rx: scoreboard bench driving the serial link and checking committed frames and flags.
module tb_segled_serial_rx;
    localparam int NBITS = 64;
    localparam int CNTW  = 7;
    typedef struct {
        logic [63:0] frame;
        logic        err;
    } exp_t;
    logic clk = 1'b0;
    logic RSTN = 1'b0;
    logic [NBITS-1:0] frame;
    logic frame_valid, frame_err, overflow;
    logic [CNTW-1:0] bit_count;
    logic [31:0] hex;
    logic [7:0] hex_ok;
    segled_serial_rx_if link ();
    segled_serial_rx #(.NBITS(NBITS), .CNTW(CNTW)) dut (
        .clk(clk), .RSTN(RSTN), .link(link), .frame(frame), .frame_valid(frame_valid),
        .frame_err(frame_err), .overflow(overflow), .bit_count(bit_count), .hex(hex), .hex_ok(hex_ok)
    );
    always #5 clk = ~clk;
    exp_t sb[$];
    exp_t mon_e;
    int checks = 0, errors = 0, nvalid = 0;
    logic [63:0] sr_m;
    int cnt_m;
    logic err_m;
    always @(negedge clk)
        if (frame_valid) begin
            nvalid++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_frame_valid: frame=%h", frame);
            end else begin
                mon_e = sb.pop_front();
                if (frame !== mon_e.frame || frame_err !== mon_e.err) begin
                    errors++;
                    $display("FAIL frame_commit: got frame=%h err=%b, expected frame=%h err=%b",
                             frame, frame_err, mon_e.frame, mon_e.err);
                end
            end
        end
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic apply_reset();
        RSTN = 1'b0;
        wait_clk(4);
        RSTN = 1'b1;
        wait_clk(4);
        sr_m = '0;
        cnt_m = 0;
        err_m = 1'b0;
        sb.delete();
    endtask
    task automatic expect_commit();
        err_m = err_m | (cnt_m != 64);
        sb.push_back('{sr_m, err_m});
        cnt_m = 0;
    endtask
    task automatic shift_bit(input logic b, input logic with_pen);
        int old_cnt, new_cnt;
        old_cnt = cnt_m;
        link.SEGLED_DO = b;
        wait_clk(4);
        link.SEGLED_CLK = 1'b1;
        if (link.SEGLED_CLR) begin
            sr_m = {sr_m[62:0], b};
            cnt_m = cnt_m < 64 ? cnt_m + 1 : 64;
        end
        if (with_pen) begin
            expect_commit();
            link.SEGLED_PEN = 1'b1;
        end
        new_cnt = cnt_m;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 2 || i == 3) begin
                checks++;
                if (bit_count !== CNTW'(i == 2 ? old_cnt : new_cnt)) begin
                    errors++;
                    $display("FAIL shift_latency cycle %0d: bit_count=%0d expected %0d",
                             i, bit_count, i == 2 ? old_cnt : new_cnt);
                end
            end
        end
        link.SEGLED_CLK = 1'b0;
        link.SEGLED_PEN = 1'b0;
    endtask
    task automatic send_bits(input logic [63:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) shift_bit(w[i], 1'b0);
    endtask
    task automatic pen_pulse();
        int v0;
        v0 = nvalid;
        expect_commit();
        link.SEGLED_PEN = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            checks++;
            if (frame_valid !== (i == 3)) begin
                errors++;
                $display("FAIL pen_latency cycle %0d: frame_valid=%b expected %b", i, frame_valid, i == 3);
            end
        end
        link.SEGLED_PEN = 1'b0;
        wait_clk(4);
        checks++;
        if (nvalid != v0 + 1) begin
            errors++;
            $display("FAIL valid_pulses: got %0d expected 1", nvalid - v0);
        end
    endtask
    task automatic test_reset();
        apply_reset();
        wait_clk(10);
        checks++;
        if ({frame, frame_valid, frame_err, overflow, bit_count, hex, hex_ok} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: frame=%h v=%b err=%b ovf=%b cnt=%0d hex=%h ok=%h",
                     frame, frame_valid, frame_err, overflow, bit_count, hex, hex_ok);
        end
        checks++;
        if (nvalid != 0) begin
            errors++;
            $display("FAIL reset_no_valid: got %0d pulses expected 0", nvalid);
        end
    endtask
    task automatic test_good_frame();
        send_bits(64'hC0F9A4B0_99929282, 64);
        pen_pulse();
        checks++;
        if (frame !== 64'hC0F9A4B0_99929282 || frame_err !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL good_frame: frame=%h err=%b ovf=%b expected C0F9A4B099929282 0 0", frame, frame_err, overflow);
        end
        checks++;
`ifdef SEGLED_RX_DECODE_EN
        if (hex !== 32'h01234556 || hex_ok !== 8'hFF) begin
            errors++;
            $display("FAIL good_decode: hex=%h ok=%h expected 01234556 ff", hex, hex_ok);
        end
`else
        if (hex !== 32'h0 || hex_ok !== 8'h0) begin
            errors++;
            $display("FAIL good_decode: hex=%h ok=%h expected 0 0", hex, hex_ok);
        end
`endif
    endtask
    task automatic test_short_frame();
        send_bits({$urandom, $urandom}, 40);
        pen_pulse();
        checks++;
        if (frame_err !== 1'b1 || bit_count !== '0) begin
            errors++;
            $display("FAIL short_frame: err=%b cnt=%0d expected 1 0", frame_err, bit_count);
        end
    endtask
    task automatic test_overflow();
        apply_reset();
        send_bits({$urandom, $urandom}, 64);
        send_bits({$urandom, $urandom}, 6);
        checks++;
        if (overflow !== 1'b1 || bit_count !== CNTW'(64)) begin
            errors++;
            $display("FAIL overflow_flag: ovf=%b cnt=%0d expected 1 64", overflow, bit_count);
        end
        pen_pulse();
        checks++;
        if (frame !== sr_m || frame_err !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_frame: frame=%h err=%b expected %h 0", frame, frame_err, sr_m);
        end
    endtask
    task automatic test_clear();
        apply_reset();
        send_bits({$urandom, $urandom}, 20);
        link.SEGLED_CLR = 1'b0;
        sr_m = '0;
        cnt_m = 0;
        wait_clk(5);
        checks++;
        if (bit_count !== '0) begin
            errors++;
            $display("FAIL clear_count: cnt=%0d expected 0", bit_count);
        end
        link.SEGLED_CLR = 1'b1;
        wait_clk(4);
        send_bits('1, 64);
        pen_pulse();
        checks++;
        if (frame !== '1 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL clear_frame: frame=%h err=%b expected all ones 0", frame, frame_err);
        end
        link.SEGLED_CLR = 1'b0;
        sr_m = '0;
        cnt_m = 0;
        wait_clk(4);
        pen_pulse();
        link.SEGLED_CLR = 1'b1;
        wait_clk(4);
        checks++;
        if (frame !== '0 || frame_err !== 1'b1) begin
            errors++;
            $display("FAIL pen_during_clear: frame=%h err=%b expected 0 1", frame, frame_err);
        end
    endtask
    task automatic test_back_to_back();
        logic [63:0] w;
        int v0;
        apply_reset();
        w = 64'hDEADBEEF_0BADF00D;
        v0 = nvalid;
        send_bits(w >> 1, 63);
        shift_bit(w[0], 1'b1);
        wait_clk(6);
        checks++;
        if (nvalid != v0 + 1 || frame !== w || frame_err !== 1'b0 || bit_count !== '0) begin
            errors++;
            $display("FAIL simultaneous_commit: pulses=%0d frame=%h err=%b cnt=%0d expected 1 %h 0 0",
                     nvalid - v0, frame, frame_err, bit_count, w);
        end
        send_bits(64'h3FF, 10);
        RSTN = 1'b0;
        #1;
        checks++;
        if ({frame, frame_valid, frame_err, overflow, bit_count, hex, hex_ok} !== '0) begin
            errors++;
            $display("FAIL async_reset: frame=%h err=%b ovf=%b cnt=%0d hex=%h ok=%h",
                     frame, frame_err, overflow, bit_count, hex, hex_ok);
        end
        wait_clk(3);
        RSTN = 1'b1;
        wait_clk(4);
        sr_m = '0;
        cnt_m = 0;
        err_m = 1'b0;
        sb.delete();
        send_bits(64'h0123456789ABCDEF, 64);
        pen_pulse();
        checks++;
        if (frame !== 64'h0123456789ABCDEF || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_frame: frame=%h err=%b expected 0123456789abcdef 0", frame, frame_err);
        end
    endtask
    initial begin
        link.SEGLED_CLK = 1'b0;
        link.SEGLED_CLR = 1'b1;
        link.SEGLED_DO  = 1'b0;
        link.SEGLED_PEN = 1'b0;
        test_reset();
        test_good_frame();
        test_short_frame();
        test_overflow();
        test_clear();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected frames never committed", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
